// File: rtl/factor_pkg.sv
// Shared types and constants for the factor search sequencer.
package factor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Smallest candidate factor; 0 and 1 are trivial.
  localparam int A_FIRST = 2;

  // Latency of the shift-add multiplier: one multiplier bit per cycle.
  function automatic int mul_cycles(input int w);
    return w;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: one bit of b per cycle, exact 2W-bit product.
module shift_add_mul
  import factor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           valid
);

  localparam int STEPS = mul_cycles(W);
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load operands on start, then add-and-shift until the bit counter drains.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CNT_W'(STEPS);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  // Multiplier state register; reset clears the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // valid marks the last step; the finished product is on prod the cycle after.
  assign valid = (cnt_q == CNT_W'(1));
  assign prod  = acc_q;

endmodule

// File: rtl/factor_search_ctrl.sv
// Walks candidate pairs (a, b), a < b, through one shared multiplier and
// reports the first pair whose product equals the latched target.
module factor_search_ctrl
  import factor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out
);

  localparam logic [W-1:0] OP_MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] TWO    = W'(2);

  state_t state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   aout_q, aout_d, bout_q, bout_d;
  logic [2*W-1:0] t_q, t_d;
  logic           found_q, found_d;

  logic           mul_start, mul_valid;
  logic [2*W-1:0] prod;

  shift_add_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a_q),
    .b     (b_q),
    .prod  (prod),
    .valid (mul_valid)
  );

  // Next-state, candidate stepping and result capture.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    found_d   = found_q;
    aout_d    = aout_q;
    bout_d    = bout_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        t_d     = target;
        a_d     = W'(A_FIRST);
        b_d     = W'(A_FIRST + 1);
        found_d = 1'b0;
        aout_d  = '0;
        bout_d  = '0;
      end
      LOAD: begin
        mul_start = 1'b1;
        state_d   = MUL;
      end
      MUL: if (mul_valid) state_d = CHECK;
      CHECK: begin
        if (prod == t_q) begin
          found_d = 1'b1;
          aout_d  = a_q;
          bout_d  = b_q;
          state_d = DONE;
        end else if (prod > t_q && b_q == a_q + ONE) begin
          // Smallest product of this and every later row already too big.
          state_d = DONE;
        end else if (prod > t_q || b_q == OP_MAX) begin
          // Row exhausted or pruned; last row has no b > a left.
          if (a_q == OP_MAX - ONE) begin
            state_d = DONE;
          end else begin
            a_d     = a_q + ONE;
            b_d     = a_q + TWO;
            state_d = LOAD;
          end
        end else begin
          b_d     = b_q + ONE;
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      found_q <= 1'b0;
      aout_q  <= '0;
      bout_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      found_q <= found_d;
      aout_q  <= aout_d;
      bout_q  <= bout_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign found = found_q;
  assign a_out = aout_q;
  assign b_out = bout_q;

endmodule

// File: tb/tb_factor_search_ctrl.sv
// Randomized and directed bench for factor_search_ctrl against a search model.
module tb_factor_search_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] target = '0;
  logic           busy, done, found;
  logic [W-1:0]   a_out, b_out;

  int  total = 0;
  int  bad   = 0;
  bit  chk_en = 1'b0;

  factor_search_ctrl #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .a_out  (a_out),
    .b_out  (b_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first lexicographic pair with a*b == t, plus how many
  // candidates the pruned walk visits before stopping.
  function automatic void search(input int t, output bit f, output int fa,
                                 output int fb, output int n);
    f = 0; fa = 0; fb = 0; n = 0;
    for (int a = 2; a <= MAXV - 1; a++) begin
      for (int b = a + 1; b <= MAXV; b++) begin
        n++;
        if (a * b == t) begin f = 1; fa = a; fb = b; return; end
        if (a * b > t) begin
          if (b == a + 1) return;
          break;
        end
      end
    end
  endfunction

  // Cycle-level expectation: k counts cycles since the accepted start.
  int m_k = 0, m_D = 0, m_a = 0, m_b = 0, m_n = 0;
  bit m_f = 0;
  bit e_found = 0;
  int e_a = 0, e_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; e_found = 0; e_a = 0; e_b = 0;
    end else if (m_k == 0) begin
      if (start) begin
        search(int'(target), m_f, m_a, m_b, m_n);
        m_D = m_n * (W + 2) + 1;
        m_k = 1; e_found = 0; e_a = 0; e_b = 0;
      end
    end else begin
      m_k++;
      if (m_k > m_D) m_k = 0;
    end
    if (m_k != 0 && m_k == m_D) begin
      e_found = m_f; e_a = m_a; e_b = m_b;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  busy,  32'(m_k != 0));
      chk("done",  done,  32'(m_k != 0 && m_k == m_D));
      chk("found", found, 32'(e_found));
      chk("a_out", a_out, 32'(e_a));
      chk("b_out", b_out, 32'(e_b));
    end
  end

  // One search: start after gap cycles, optionally poke a stray start at
  // cycle inj, return at the negedge where done is seen.
  task automatic run(input int t, input int gap, input int inj, output int cyc);
    bit f; int fa, fb, n;
    search(t, f, fa, fb, n);
    repeat (gap) @(negedge clk);
    start = 1'b1;
    target = (2*W)'(t);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inj);
      if (cyc == inj) target = 8'd15;
    end
    start = 1'b0;
    chk("latency", cyc, n * (W + 2) + 1);
  endtask

  task automatic expect_res(input string name, input bit f, input int a, input int b);
    chk({name, "_found"}, found, 32'(f));
    chk({name, "_a"}, a_out, a);
    chk({name, "_b"}, b_out, b);
  endtask

  initial begin
    int cyc;
    int t, gap, inj;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    @(negedge clk);
    rst = 1'b0;

    run(143, 1, -1, cyc); expect_res("t143", 1, 11, 13);
    run(15,  1, -1, cyc); expect_res("t15", 1, 3, 5);
    run(13,  2, -1, cyc); expect_res("t13", 0, 0, 0);
    run(4,   1, -1, cyc); expect_res("t4", 0, 0, 0);
    run(0,   1, -1, cyc); expect_res("t0", 0, 0, 0);
    chk("t0_latency", cyc, W + 3);
    run(210, 1, -1, cyc); expect_res("t210", 1, 14, 15);
    run(225, 1, -1, cyc); expect_res("t225", 0, 0, 0);

    // Stray start mid-search must be ignored.
    run(143, 1, 5, cyc); expect_res("t143_inj", 1, 11, 13);

    // Reset during MUL, then a fresh search.
    @(negedge clk);
    start = 1'b1; target = 8'd143;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    expect_res("midrst", 0, 0, 0);
    run(15, 1, -1, cyc); expect_res("after_rst", 1, 3, 5);

    // Back-to-back: start in the cycle right after done.
    run(143, 1, -1, cyc);
    run(35, 1, -1, cyc); expect_res("b2b", 1, 5, 7);

    // Randomized targets, gaps and stray starts.
    for (int i = 0; i < 40; i++) begin
      bit f; int fa, fb, n;
      t   = $urandom_range(0, 255);
      gap = $urandom_range(1, 4);
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : -1;
      search(t, f, fa, fb, n);
      run(t, gap, inj, cyc);
      expect_res("rand", f, fa, fb);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
